draw_cmd_sequencer: RTL and testbench
=====================================

// Module: draw_cmd_sequencer
// PURPOSE
//  Queues Reuleaux-draw commands {centre_x, centre_y, diameter, colour} from a host/top FSM and
//  sequences them one at a time into the reuleaux drawing engine via its start/done handshake.
//  Sits between the top-level control and the reuleaux engine; engine VGA outputs bypass this block.
//  Gives the top level fire-and-forget drawing plus a busy flag and a completed-shape count.
// PARAMETERS
//  DEPTH  4   command queue entries (power of 2, >=2)
//  CNT_W  16  width of completed-shape counter
// PORTS
//  clk           in   1      system clock
//  rst_n         in   1      asynchronous active-low reset
//  cmd_valid     in   1      host offers a command this cycle
//  cmd_ready     out  1      queue can accept (= !full)
//  cmd_centre_x  in   8      command centre x (0..159)
//  cmd_centre_y  in   7      command centre y (0..119)
//  cmd_diameter  in   8      command diameter
//  cmd_colour    in   3      command colour
//  flush         in   1      synchronous queue clear
//  eng_start     out  1      start to engine
//  eng_centre_x  out  8      engine operand, held stable while eng_start=1
//  eng_centre_y  out  7      engine operand
//  eng_diameter  out  8      engine operand
//  eng_colour    out  3      engine operand
//  eng_done      in   1      engine done (high until start drops)
//  busy          out  1      state!=IDLE or queue non-empty
//  level         out  $clog2(DEPTH)+1  queued entry count
//  drawn_count   out  CNT_W  completed shapes, wraps mod 2^CNT_W
// BEHAVIOUR
//  Reset: queue empty, state IDLE, eng_start=0, eng_* operands=0, drawn_count=0, level=0, busy=0, cmd_ready=1.
//  Push: cmd_valid&&cmd_ready at edge. cmd_ready depends only on full; a same-cycle pop does not enable a push when full.
//  No bypass: a push into an empty queue is visible to the FSM the next cycle.
//  FSM (registered outputs):
//   IDLE    : queue non-empty -> LOAD; pop head into eng_* registers.
//   LOAD    : -> RUN; eng_start<=1.
//   RUN     : eng_start=1, operands frozen; eng_done=1 -> RELEASE, eng_start<=0, drawn_count++.
//   RELEASE : eng_start=0; wait eng_done=0 -> IDLE. Next command never starts while eng_done is high.
//  Latency: push at edge k into idle empty block -> LOAD at k+1 -> eng_start=1 at k+2.
//  Back-to-back: RELEASE->IDLE->LOAD->RUN gives 3 cycles minimum between done falling and next start.
//  eng_done high in IDLE/LOAD is ignored; no count increment.
//  flush: empties queue and clears level that cycle; concurrent push is dropped. An in-flight draw (LOAD/RUN/RELEASE) completes normally.
//  Queue pointers wrap mod DEPTH; level saturates only by cmd_ready gating (never >DEPTH, never <0).
//  drawn_count wraps from 2^CNT_W-1 to 0.
//  Async reset mid-draw: eng_start drops immediately; the queue is lost. The top level resets the engine alongside.
// STRUCTURE
//  Package draw_pkg: typedef struct packed draw_cmd_t {x[7:0], y[6:0], diam[7:0], colour[2:0]};
//   typedef enum seq_state_t {IDLE, LOAD, RUN, RELEASE}; localparam SCREEN_W=160, SCREEN_H=120.
//  Sub-module draw_cmd_fifo: DEPTH-entry synchronous FIFO of draw_cmd_t with push/pop/flush/full/empty/level.
//  The sequencer FSM, operand registers, and counter reside in the top module.
// TESTING
//  1. Reset, push (80,60,40,010); engine model asserts done 50 cycles after start -> eng_start rises 2 cycles after push,
//     operands=(80,60,40,010) stable until done, drawn_count=1, busy=0 after done drops.
//  2. Push 4 commands back-to-back while idle -> cmd_ready=0 after 4th accepted push (level=4 minus any pop);
//     executed in FIFO order; drawn_count=4.
//  3. Full queue plus draw in flight; cmd_valid held high -> no push until a pop; no entry lost or duplicated.
//  4. Engine holds done high 10 cycles after start drops -> next eng_start stays 0 until done=0, then rises 3 cycles later.
//  5. Flush with 3 queued and one in RUN -> level=0 next cycle; current draw completes; drawn_count increments by exactly 1.
//  6. rst_n low mid-RUN -> eng_start=0 asynchronously; all outputs at reset values; a push after release works normally.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types for the Reuleaux draw-command path: the queued command word,
// the sequencer state encoding and the screen bounds.
package draw_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] diam;
    logic [2:0] colour;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RELEASE
  } seq_state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

endpackage

// File: rtl/draw_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of draw commands. Full/empty derive from a
// registered occupancy count; flush clears everything and wins over push/pop.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  draw_cmd_t                wr_data,
  output draw_cmd_t                rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  draw_cmd_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/draw_cmd_sequencer.sv
// Queues Reuleaux draw commands and feeds them one at a time to the drawing
// engine over its start/done handshake; counts completed shapes.
module draw_cmd_sequencer
  import draw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_centre_x,
  input  logic [6:0]              cmd_centre_y,
  input  logic [7:0]              cmd_diameter,
  input  logic [2:0]              cmd_colour,
  input  logic                    flush,
  output logic                    eng_start,
  output logic [7:0]              eng_centre_x,
  output logic [6:0]              eng_centre_y,
  output logic [7:0]              eng_diameter,
  output logic [2:0]              eng_colour,
  input  logic                    eng_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        drawn_count
);

  seq_state_t state;
  draw_cmd_t  in_cmd;
  draw_cmd_t  head;
  logic       full;
  logic       empty;
  logic       pop;

  assign in_cmd    = {cmd_centre_x, cmd_centre_y, cmd_diameter, cmd_colour};
  assign cmd_ready = !full;
  // A flushed queue has nothing valid to hand over, so no launch that cycle.
  assign pop       = (state == IDLE) && !empty && !flush;
  assign busy      = (state != IDLE) || !empty;

  draw_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid),
    .pop     (pop),
    .flush   (flush),
    .wr_data (in_cmd),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      eng_start    <= 1'b0;
      eng_centre_x <= '0;
      eng_centre_y <= '0;
      eng_diameter <= '0;
      eng_colour   <= '0;
      drawn_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            eng_centre_x <= head.x;
            eng_centre_y <= head.y;
            eng_diameter <= head.diam;
            eng_colour   <= head.colour;
            state        <= LOAD;
          end
        end
        LOAD: begin
          eng_start <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (eng_done) begin
            eng_start   <= 1'b0;
            drawn_count <= drawn_count + 1'b1;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          // Engine keeps done high until it sees start low; wait it out.
          if (!eng_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Randomised and directed bench for draw_cmd_sequencer against a queue-based
// reference model and a behavioural drawing-engine responder.
module tb_draw_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_centre_x;
  logic [6:0]       cmd_centre_y;
  logic [7:0]       cmd_diameter;
  logic [2:0]       cmd_colour;
  logic             flush;
  logic             eng_start;
  logic [7:0]       eng_centre_x;
  logic [6:0]       eng_centre_y;
  logic [7:0]       eng_diameter;
  logic [2:0]       eng_colour;
  logic             eng_done;
  logic             busy;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] drawn_count;

  draw_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_centre_x (cmd_centre_x),
    .cmd_centre_y (cmd_centre_y),
    .cmd_diameter (cmd_diameter),
    .cmd_colour   (cmd_colour),
    .flush        (flush),
    .eng_start    (eng_start),
    .eng_centre_x (eng_centre_x),
    .eng_centre_y (eng_centre_y),
    .eng_diameter (eng_diameter),
    .eng_colour   (eng_colour),
    .eng_done     (eng_done),
    .busy         (busy),
    .level        (level),
    .drawn_count  (drawn_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: pending commands, the command currently handed to the
  // engine, where the current draw is in its lifecycle, and shapes finished.
  localparam int P_FREE = 0, P_LAUNCH = 1, P_DRAW = 2, P_DRAIN = 3;
  logic [25:0] mq[$];
  logic [25:0] m_cur;
  int          m_phase;
  int          m_count;
  bit          m_pushed;

  // Engine responder settings and state
  int e_lat  = 5;
  int e_hold = 0;
  int e_cnt  = 0;
  int h_cnt  = 0;

  function automatic logic [25:0] cmd_word();
    return {cmd_centre_x, cmd_centre_y, cmd_diameter, cmd_colour};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cur   = '0;
    m_phase = P_FREE;
    m_count = 0;
  endtask

  task automatic model_edge();
    bit take, accept;
    m_pushed = 1'b0;
    if (!rst_n) return;
    take   = (m_phase == P_FREE) && (mq.size() != 0) && !flush;
    accept = cmd_valid && (mq.size() < DEPTH) && !flush;
    case (m_phase)
      P_FREE:   if (take) begin m_cur = mq.pop_front(); m_phase = P_LAUNCH; end
      P_LAUNCH: m_phase = P_DRAW;
      P_DRAW:   if (eng_done) begin m_count = (m_count + 1) % (1 << CNT_W); m_phase = P_DRAIN; end
      default:  if (!eng_done) m_phase = P_FREE;
    endcase
    if (flush) mq.delete();
    if (accept) begin mq.push_back(cmd_word()); m_pushed = 1'b1; end
  endtask

  task automatic compare();
    check("cmd_ready",   cmd_ready, mq.size() < DEPTH);
    check("level",       level, mq.size());
    check("busy",        busy, (m_phase != P_FREE) || (mq.size() != 0));
    check("eng_start",   eng_start, m_phase == P_DRAW);
    check("operands",    {eng_centre_x, eng_centre_y, eng_diameter, eng_colour}, m_cur);
    check("drawn_count", drawn_count, m_count);
  endtask

  task automatic engine_drive();
    if (!rst_n) begin
      eng_done = 1'b0; e_cnt = 0; h_cnt = 0;
    end else if (eng_start) begin
      h_cnt = 0;
      if (!eng_done) begin
        e_cnt++;
        if (e_cnt >= e_lat) eng_done = 1'b1;
      end
    end else begin
      e_cnt = 0;
      if (eng_done) begin
        if (h_cnt >= e_hold) eng_done = 1'b0;
        else h_cnt++;
      end
    end
  endtask

  // One clock: model follows the edge, outputs checked 1ns later, engine reacts.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
    engine_drive();
  endtask

  task automatic rand_cmd();
    cmd_centre_x = 8'($urandom_range(0, 159));
    cmd_centre_y = 7'($urandom_range(0, 119));
    cmd_diameter = 8'($urandom);
    cmd_colour   = 3'($urandom);
  endtask

  task automatic push_one();
    rand_cmd();
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((busy || eng_start || eng_done) && n < budget) begin cycle(); n++; end
    if (n >= budget) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_level(input logic want_start, input logic want_done, input bit use_done,
                            input int budget, input string tag);
    int n = 0;
    while ((use_done ? (eng_done !== want_done) : (eng_start !== want_start)) && n < budget) begin
      cycle(); n++;
    end
    if (n >= budget) check(tag, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; flush = 1'b0; eng_done = 1'b0;
    cmd_centre_x = '0; cmd_centre_y = '0; cmd_diameter = '0; cmd_colour = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base, t_fall;

    // 1: reset values, single command latency and operand hold
    do_reset();
    compare();
    e_lat = 50; e_hold = 0;
    cmd_centre_x = 8'd80; cmd_centre_y = 7'd60; cmd_diameter = 8'd40; cmd_colour = 3'b010;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    check("t1_no_start_yet", eng_start, 0);
    cycle();
    check("t1_start_2cyc", eng_start, 1);
    check("t1_operands", {eng_centre_x, eng_centre_y, eng_diameter, eng_colour},
          {8'd80, 7'd60, 8'd40, 3'b010});
    run_until_idle(200);
    check("t1_count", drawn_count, 1);
    check("t1_busy", busy, 0);

    // 2: four back-to-back pushes, executed in order
    e_lat = 4;
    repeat (4) push_one();
    run_until_idle(300);
    check("t2_count", drawn_count, 5);

    // 3: full queue with a draw in flight; valid held, payload changes only on accept
    e_lat = 30;
    rand_cmd();
    cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (m_pushed) rand_cmd();
    end
    cmd_valid = 1'b0;
    run_until_idle(1000);

    // 4: engine holds done 10 cycles after start drops
    e_lat = 3; e_hold = 10;
    push_one(); push_one();
    wait_level(1'b1, 1'b0, 1'b0, 50, "t4_first_start");
    wait_level(1'b0, 1'b0, 1'b0, 50, "t4_start_drop");
    wait_level(1'b0, 1'b0, 1'b1, 50, "t4_done_drop");
    t_fall = cyc;
    wait_level(1'b1, 1'b0, 1'b0, 50, "t4_second_start");
    check("t4_gap_3", cyc - t_fall, 3);
    run_until_idle(200);
    e_hold = 0;

    // 5: flush with three queued and one drawing
    e_lat = 40;
    base = m_count;
    repeat (4) push_one();
    wait_level(1'b1, 1'b0, 1'b0, 50, "t5_start");
    check("t5_level3", level, 3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("t5_level0", level, 0);
    run_until_idle(200);
    check("t5_count", drawn_count, (base + 1) % (1 << CNT_W));

    // 6: asynchronous reset mid-draw
    e_lat = 40;
    push_one(); push_one();
    wait_level(1'b1, 1'b0, 1'b0, 50, "t6_start");
    repeat (3) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_start_async", eng_start, 0);
    check("t6_level", level, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", cmd_ready, 1);
    check("t6_count", drawn_count, 0);
    check("t6_operands", {eng_centre_x, eng_centre_y, eng_diameter, eng_colour}, 0);
    model_reset();
    eng_done = 1'b0; e_cnt = 0; h_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e_lat = 6;
    push_one();
    run_until_idle(200);
    check("t6_after_reset", drawn_count, 1);

    // 7: random traffic, random engine timing, stray done pulses, rare flushes
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      rand_cmd();
      flush = ($urandom_range(0, 39) == 0);
      if (!eng_start && !eng_done) begin
        e_lat  = $urandom_range(1, 8);
        e_hold = $urandom_range(0, 4);
        if ($urandom_range(0, 24) == 0) eng_done = 1'b1;
      end
      cycle();
    end
    cmd_valid = 1'b0; flush = 1'b0;
    run_until_idle(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
